ucomb_cfg_ctrl: RTL and testbench
=================================

Name: ucomb_cfg_ctrl

Overview:
Configuration loader and evaluation sequencer for the ucomb universal-gate block.
- Accepts a serial configuration frame over a valid/ready handshake, then commits it atomically to shadow registers. The shadow registers drive the config inputs of u21/u31/u41/u22.
- On request, runs a two-step sweep: drives u22_sel to 0 and then to 1, and captures mux_out each time, so software can read back both u22 outputs.
- Sits between the host-side register interface and ucomb.

Parameters:
- CFG_W, 26: frame length in bits (4+6+10+6). Fixed by the ucomb input widths and not overridden.
- SETTLE, 2: cycles u22_sel is held before mux_out is sampled. Legal range 1..15.

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- cfg_valid  in  1  serial config bit valid
- cfg_bit  in  1  serial config data bit
- cfg_last  in  1  marks final bit of frame; qualified by cfg_valid
- cfg_ready  out  1  controller can accept a config bit
- cfg_done  out  1  one-cycle pulse: new config committed
- cfg_err  out  1  one-cycle pulse: frame rejected
- sweep_start  in  1  request a sweep; level sampled in IDLE only
- mux_out  in  1  from ucomb.mux_out
- u21_cfg  out  4  to ucomb.u21_in
- u31_cfg  out  6  to ucomb.u31_in
- u41_cfg  out  10  to ucomb.u41_in
- u22_cfg  out  6  to ucomb.u22_in
- u22_sel  out  1  to ucomb.u22_sel
- result  out  2  result[0] = mux_out sampled with sel=0; result[1] = mux_out sampled with sel=1
- res_valid  out  1  one-cycle pulse: result updated
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE
  - shift register=0, bit counter=0
  - all *_cfg=0, u22_sel=0, result=0
  - cfg_done=0, cfg_err=0, res_valid=0
  - busy=0; cfg_ready=1 once rst_n deasserts
- Reset asserted mid-frame or mid-sweep discards all progress. Shadow config returns to 0.
- Accept rule: a bit transfers on a rising edge where cfg_valid && cfg_ready.
- Shift rule: shift <= {shift[CFG_W-2:0], cfg_bit}, so the first bit received ends up in bit 25.
- Shadow mapping on commit:
  - u21_cfg = shift[25:22]
  - u31_cfg = shift[21:16]
  - u41_cfg = shift[15:6]
  - u22_cfg = shift[5:0]
- States:
  - IDLE:
    - cfg_ready=1.
    - Accepted bit -> LOAD, cnt=1. If that bit also carries cfg_last, treat it as a short frame: pulse cfg_err, stay in IDLE.
    - Otherwise, sweep_start=1 -> SWEEP0, settle counter=0.
    - If cfg_valid and sweep_start are both high in the same cycle, config wins and sweep_start is dropped, not queued.
  - LOAD:
    - cfg_ready=1; each accepted bit increments cnt.
    - Accepted bit with cnt==CFG_W-1 and cfg_last=1 -> COMMIT.
    - cfg_last=1 at any other count, or cnt==CFG_W-1 without cfg_last -> IDLE. cfg_err pulses the next cycle. Shadow is unchanged and the shift register is cleared.
    - Idle cycles (cfg_valid=0) are allowed indefinitely. There is no timeout.
    - sweep_start is ignored.
  - COMMIT:
    - Lasts one cycle, with cfg_ready=0.
    - At the end of this cycle the shadow is loaded from shift and cfg_done is set.
    - Both the new *_cfg values and the cfg_done pulse are visible in the cycle after COMMIT. Next state: IDLE.
    - Latency: last bit accepted at edge E -> new config visible after edge E+1.
  - SWEEP0:
    - u22_sel=0 and cfg_ready=0.
    - Settle counter counts up to SETTLE-1. On that cycle mux_out is captured into a holding bit.
    - Then -> SWEEP1 with the settle counter cleared.
  - SWEEP1:
    - u22_sel=1. After SETTLE cycles, capture mux_out.
    - result <= {captured_sel1, captured_sel0} and res_valid=1, visible the following cycle.
    - -> IDLE; u22_sel returns to 0.
- Sweep timing: start sampled at edge S.
  - u22_sel=1 after edge S+SETTLE.
  - res_valid is high after edge S+2*SETTLE for one cycle.
- Config shadow never changes during a sweep.
- result holds its value until the next completed sweep.
- Pulse outputs are registered and never overlap: cfg_done, cfg_err and res_valid are mutually exclusive per cycle.
- u22_sel is 0 in every state except SWEEP1.

Test Plan:
1. Reset, then send 26 bits, MSB-first, forming the word 0x2A5_5A5C, with cfg_last on bit 26 -> cfg_done pulse once, one cycle after the COMMIT state. u21_cfg=0xA, u31_cfg=0x25, u41_cfg=0x169, u22_cfg=0x1C. busy=0 afterwards.
2. Send 10 bits with cfg_last on the 10th -> cfg_err pulses, *_cfg unchanged from test 1. Send 26 bits with no cfg_last -> cfg_err; an extra 27th bit then restarts LOAD (cnt=1).
3. Full frame with cfg_valid toggling 1/0 every cycle -> identical commit to test 1. cfg_ready is high throughout LOAD and low in the COMMIT cycle.
4. Bench models mux_out = ~u22_sel; pulse sweep_start with SETTLE=2 -> u22_sel goes high 2 cycles after start, res_valid after 4 cycles, result=2'b01. Repeat with SETTLE=5 -> res_valid after 10 cycles.
5. cfg_valid and sweep_start raised together in IDLE -> LOAD is entered, no sweep occurs, and res_valid never pulses. sweep_start held during LOAD -> ignored until IDLE.
6. Deassert rst_n mid-frame (bit 13) and again mid-sweep (SWEEP1) -> all outputs return to 0 immediately, with no cfg_done or res_valid pulse. The next full frame commits correctly.

Source files
------------

// File: rtl/ucomb_cfg_ctrl.sv
// Configuration loader and two-step evaluation sequencer for the ucomb universal-gate block.
// Serial frames are shifted in and committed atomically to the shadow registers that drive ucomb.
module ucomb_cfg_ctrl #(
    parameter int CFG_W  = 26,
    parameter int SETTLE = 2     // legal range 1..15 (settle counter is 4 bits)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_valid,
    input  logic       cfg_bit,
    input  logic       cfg_last,
    output logic       cfg_ready,
    output logic       cfg_done,
    output logic       cfg_err,
    input  logic       sweep_start,
    input  logic       mux_out,
    output logic [3:0] u21_cfg,
    output logic [5:0] u31_cfg,
    output logic [9:0] u41_cfg,
    output logic [5:0] u22_cfg,
    output logic       u22_sel,
    output logic [1:0] result,
    output logic       res_valid,
    output logic       busy
);

    localparam int                CNT_W       = $clog2(CFG_W);
    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(CFG_W - 1);
    localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMMIT,
        SWEEP0,
        SWEEP1
    } state_t;

    state_t             state_q, state_d;
    logic [CFG_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         settle_q, settle_d;
    logic               hold0_q, hold0_d;
    logic [1:0]         result_d;
    logic               commit;
    logic               done_d, err_d, res_d;
    logic               rx_state;

    assign rx_state  = (state_q == IDLE) || (state_q == LOAD);
    // Ready is forced low while reset is held so the host sees no acceptance window.
    assign cfg_ready = rst_n && rx_state;
    assign busy      = (state_q != IDLE);
    assign u22_sel   = (state_q == SWEEP1);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        hold0_d  = hold0_q;
        result_d = result;
        commit   = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        res_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // A config bit always wins over a sweep request arriving in the same cycle.
                if (cfg_valid) begin
                    if (cfg_last) begin
                        err_d   = 1'b1;
                        shift_d = '0;
                    end else begin
                        state_d = LOAD;
                        cnt_d   = CNT_W'(1);
                        shift_d = {shift_q[CFG_W-2:0], cfg_bit};
                    end
                end else if (sweep_start) begin
                    state_d  = SWEEP0;
                    settle_d = '0;
                end
            end

            LOAD: begin
                if (cfg_valid) begin
                    shift_d = {shift_q[CFG_W-2:0], cfg_bit};
                    if (cnt_q == CNT_LAST && cfg_last) begin
                        state_d = COMMIT;
                    end else if (cfg_last || cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                        shift_d = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            COMMIT: begin
                commit  = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
                shift_d = '0;
                cnt_d   = '0;
            end

            SWEEP0: begin
                if (settle_q == SETTLE_LAST) begin
                    hold0_d  = mux_out;
                    settle_d = '0;
                    state_d  = SWEEP1;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end

            SWEEP1: begin
                if (settle_q == SETTLE_LAST) begin
                    result_d = {mux_out, hold0_q};
                    res_d    = 1'b1;
                    settle_d = '0;
                    state_d  = IDLE;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            settle_q  <= '0;
            hold0_q   <= 1'b0;
            result    <= '0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            settle_q  <= settle_d;
            hold0_q   <= hold0_d;
            result    <= result_d;
            cfg_done  <= done_d;
            cfg_err   <= err_d;
            res_valid <= res_d;
        end
    end

    // Shadow registers only move on commit, so a sweep never sees the config change under it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u21_cfg <= '0;
            u31_cfg <= '0;
            u41_cfg <= '0;
            u22_cfg <= '0;
        end else if (commit) begin
            u21_cfg <= shift_q[25:22];
            u31_cfg <= shift_q[21:16];
            u41_cfg <= shift_q[15:6];
            u22_cfg <= shift_q[5:0];
        end
    end

endmodule

// File: tb/tb_ucomb_cfg_ctrl.sv
// Self-checking bench for ucomb_cfg_ctrl: directed frames/sweeps, a vector table, and a
// randomized transaction-level model of the committed shadow word and sweep result.
module tb_ucomb_cfg_ctrl;

    typedef struct {
        logic [25:0] word;
        int          len;
        bit          last;
        bit          exp_done;
        bit          exp_err;
        logic [25:0] exp_shadow;
    } frame_vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0, cfg_bit = 1'b0, cfg_last = 1'b0, sweep_start = 1'b0;
    logic       m0 = 1'b1, m1 = 1'b0;
    logic       mux_out, mux5;
    logic       cfg_ready, cfg_done, cfg_err, u22_sel, res_valid, busy;
    logic [3:0] u21_cfg;
    logic [5:0] u31_cfg, u22_cfg;
    logic [9:0] u41_cfg;
    logic [1:0] result;
    logic       cfg_ready5, cfg_done5, cfg_err5, u22_sel5, res_valid5, busy5;
    logic [3:0] u21_5;
    logic [5:0] u31_5, u22_5;
    logic [9:0] u41_5;
    logic [1:0] result5;

    int tests = 0, fails = 0;
    int done_cnt = 0, err_cnt = 0, res_cnt = 0, res5_cnt = 0;
    int overlap_cnt = 0, sel_idle_cnt = 0, ready_viol = 0;

    localparam logic [25:0] W1 = 26'h2A55A5C;
    localparam logic [25:0] W2 = 26'h0F0F0F3;
    localparam logic [25:0] W3 = 26'h1C3A7B2;

    always #5 clk = ~clk;

    // ucomb's mux output is modelled as the value selected by u22_sel from two bench-held bits.
    assign mux_out = u22_sel  ? m1 : m0;
    assign mux5    = u22_sel5 ? m1 : m0;

    ucomb_cfg_ctrl #(.CFG_W(26), .SETTLE(2)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit), .cfg_last(cfg_last),
        .cfg_ready(cfg_ready), .cfg_done(cfg_done), .cfg_err(cfg_err), .sweep_start(sweep_start),
        .mux_out(mux_out), .u21_cfg(u21_cfg), .u31_cfg(u31_cfg), .u41_cfg(u41_cfg),
        .u22_cfg(u22_cfg), .u22_sel(u22_sel), .result(result), .res_valid(res_valid), .busy(busy)
    );

    ucomb_cfg_ctrl #(.CFG_W(26), .SETTLE(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit), .cfg_last(cfg_last),
        .cfg_ready(cfg_ready5), .cfg_done(cfg_done5), .cfg_err(cfg_err5), .sweep_start(sweep_start),
        .mux_out(mux5), .u21_cfg(u21_5), .u31_cfg(u31_5), .u41_cfg(u41_5),
        .u22_cfg(u22_5), .u22_sel(u22_sel5), .result(result5), .res_valid(res_valid5), .busy(busy5)
    );

    always @(negedge clk) begin
        if (cfg_done)   done_cnt++;
        if (cfg_err)    err_cnt++;
        if (res_valid)  res_cnt++;
        if (res_valid5) res5_cnt++;
        if (int'(cfg_done) + int'(cfg_err) + int'(res_valid) > 1) overlap_cnt++;
        if (u22_sel && !busy) sel_idle_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [25:0] shadow();
        return {u21_cfg, u31_cfg, u41_cfg, u22_cfg};
    endfunction

    task automatic send_bit(input logic b, input logic last);
        cfg_valid = 1'b1;
        cfg_bit   = b;
        cfg_last  = last;
        if (!cfg_ready) ready_viol++;
        step();
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    // gap: 0 = back-to-back, 1 = one idle cycle between bits, 2 = random idle cycles
    task automatic send_frame(input logic [25:0] word, input int first, input int len,
                              input bit last, input int gap);
        for (int i = first; i < len; i++) begin
            send_bit(word[25-i], last && (i == len - 1));
            if (i != len - 1) begin
                int n;
                n = (gap == 2) ? int'($urandom_range(0, 3)) : gap;
                for (int g = 0; g < n; g++) begin
                    if (!cfg_ready) ready_viol++;
                    step();
                end
            end
        end
    endtask

    task automatic run_sweep(output int sr2, output int sr5, output int rv2, output int rv5);
        sr2 = -1; sr5 = -1; rv2 = -1; rv5 = -1;
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        for (int m = 0; m <= 40; m++) begin
            if (u22_sel    && sr2 < 0) sr2 = m;
            if (u22_sel5   && sr5 < 0) sr5 = m;
            if (res_valid  && rv2 < 0) rv2 = m;
            if (res_valid5 && rv5 < 0) rv5 = m;
            if (rv2 >= 0 && rv5 >= 0) break;
            step();
        end
    endtask

    initial begin
        frame_vec_t  vec [8];
        logic [25:0] model_word;
        int sr2, sr5, rv2, rv5, d0, e0, r0, r50, v0;

        vec[0] = '{26'h3FFFFFF, 26, 1'b1, 1'b1, 1'b0, 26'h3FFFFFF};
        vec[1] = '{26'h0000001, 26, 1'b1, 1'b1, 1'b0, 26'h0000001};
        vec[2] = '{26'h2A55A5C, 10, 1'b1, 1'b0, 1'b1, 26'h0000001};
        vec[3] = '{26'h1555555, 26, 1'b1, 1'b1, 1'b0, 26'h1555555};
        vec[4] = '{26'h1555555,  1, 1'b1, 1'b0, 1'b1, 26'h1555555};
        vec[5] = '{26'h0ABCDEF, 26, 1'b0, 1'b0, 1'b1, 26'h1555555};
        vec[6] = '{26'h0ABCDEF, 25, 1'b1, 1'b0, 1'b1, 26'h1555555};
        vec[7] = '{26'h2000000, 26, 1'b1, 1'b1, 1'b0, 26'h2000000};

        // Reset state
        step(); step();
        check("rst_busy", busy, 0);
        check("rst_shadow", shadow(), 0);
        rst_n = 1'b1;
        step();
        check("rst_ready", cfg_ready, 1);
        check("rst_sel", u22_sel, 0);
        check("rst_result", result, 0);
        check("rst_pulses", {cfg_done, cfg_err, res_valid}, 0);

        // Test 1: full frame, commit latency
        d0 = done_cnt;
        send_frame(W1, 0, 26, 1'b1, 0);
        check("t1_commit_ready", cfg_ready, 0);
        check("t1_commit_busy", busy, 1);
        check("t1_commit_nodone", cfg_done, 0);
        check("t1_commit_old_shadow", shadow(), 0);
        step();
        check("t1_done", cfg_done, 1);
        check("t1_u21", u21_cfg, 4'hA);
        check("t1_u31", u31_cfg, 6'h25);
        check("t1_u41", u41_cfg, 10'h169);
        check("t1_u22", u22_cfg, 6'h1C);
        check("t1_busy", busy, 0);
        step();
        check("t1_done_once", done_cnt - d0, 1);

        // Test 2: short frame, frame without last, restart
        send_frame(W2, 0, 10, 1'b1, 0);
        check("t2_short_err", cfg_err, 1);
        check("t2_short_busy", busy, 0);
        step();
        check("t2_err_pulse", cfg_err, 0);
        check("t2_shadow_kept", shadow(), W1);
        send_frame(W3, 0, 26, 1'b0, 0);
        check("t2_nolast_err", cfg_err, 1);
        check("t2_nolast_busy", busy, 0);
        send_bit(W2[25], 1'b0);
        check("t2_restart_load", busy, 1);
        send_frame(W2, 1, 26, 1'b1, 0);
        step();
        check("t2_restart_done", cfg_done, 1);
        check("t2_restart_shadow", shadow(), W2);

        // Test 3: valid toggling every cycle
        v0 = ready_viol;
        send_frame(W1, 0, 26, 1'b1, 1);
        check("t3_commit_ready", cfg_ready, 0);
        step();
        check("t3_done", cfg_done, 1);
        check("t3_shadow", shadow(), W1);
        check("t3_ready_in_load", ready_viol - v0, 0);

        // Test 4: sweep timing for SETTLE=2 and SETTLE=5, mux_out = ~u22_sel
        m0 = 1'b1; m1 = 1'b0;
        r0 = res_cnt; r50 = res5_cnt;
        run_sweep(sr2, sr5, rv2, rv5);
        check("t4_sel_rise_s2", sr2, 2);
        check("t4_resv_s2", rv2, 4);
        check("t4_sel_rise_s5", sr5, 5);
        check("t4_resv_s5", rv5, 10);
        check("t4_result_s2", result, 2'b01);
        check("t4_result_s5", result5, 2'b01);
        check("t4_res_once", res_cnt - r0, 1);
        check("t4_res5_once", res5_cnt - r50, 1);
        check("t4_shadow_kept", shadow(), W1);
        check("t4_idle", busy, 0);

        // Test 5: config beats a simultaneous sweep request; sweep_start ignored in LOAD
        r0 = res_cnt;
        cfg_valid = 1'b1; cfg_bit = W3[25]; cfg_last = 1'b0; sweep_start = 1'b1;
        step();
        cfg_valid = 1'b0;
        check("t5_load_entered", busy, 1);
        check("t5_no_sel", u22_sel, 0);
        send_frame(W3, 1, 25, 1'b0, 0);
        sweep_start = 1'b0;
        send_bit(W3[0], 1'b1);
        step();
        check("t5_done", cfg_done, 1);
        check("t5_shadow", shadow(), W3);
        step(); step(); step(); step();
        check("t5_no_sweep", res_cnt - r0, 0);

        // Table-driven frames
        for (int k = 0; k < 8; k++) begin
            d0 = done_cnt; e0 = err_cnt;
            send_frame(vec[k].word, 0, vec[k].len, vec[k].last, 0);
            step(); step(); step();
            check($sformatf("vec%0d_done", k), done_cnt - d0, 32'(vec[k].exp_done));
            check($sformatf("vec%0d_err", k), err_cnt - e0, 32'(vec[k].exp_err));
            check($sformatf("vec%0d_shadow", k), shadow(), vec[k].exp_shadow);
        end

        // Randomized transactions against the frame/sweep model
        model_word = 26'h2000000;
        for (int k = 0; k < 40; k++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            if (kind < 3) begin
                logic [25:0] w;
                int  len;
                bit  last;
                bit  ok;
                w = 26'($urandom);
                if (kind < 2) begin
                    len = 26; last = 1'b1;
                end else if ($urandom_range(0, 1) == 0) begin
                    len = int'($urandom_range(1, 25)); last = 1'b1;
                end else begin
                    len = 26; last = 1'b0;
                end
                ok = (len == 26) && last;
                if (ok) model_word = w;
                d0 = done_cnt; e0 = err_cnt;
                send_frame(w, 0, len, last, 2);
                step(); step(); step();
                check($sformatf("rnd%0d_done", k), done_cnt - d0, 32'(ok));
                check($sformatf("rnd%0d_err", k), err_cnt - e0, 32'(!ok));
                check($sformatf("rnd%0d_shadow", k), shadow(), model_word);
            end else begin
                m0 = 1'($urandom); m1 = 1'($urandom);
                run_sweep(sr2, sr5, rv2, rv5);
                check($sformatf("rnd%0d_resv", k), rv2, 4);
                check($sformatf("rnd%0d_result", k), result, {m1, m0});
                check($sformatf("rnd%0d_result5", k), result5, {m1, m0});
            end
        end
        check("rnd_shadow5", {u21_5, u31_5, u41_5, u22_5}, model_word);

        // Test 6: reset mid-frame, then mid-sweep
        d0 = done_cnt;
        send_frame(W2, 0, 13, 1'b0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t6a_busy", busy, 0);
        check("t6a_ready", cfg_ready, 0);
        check("t6a_shadow", shadow(), 0);
        check("t6a_result", result, 0);
        step();
        rst_n = 1'b1;
        step();
        check("t6a_ready_after", cfg_ready, 1);
        check("t6a_no_done", done_cnt - d0, 0);

        send_frame(W1, 0, 26, 1'b1, 0);
        step();
        m0 = 1'b1; m1 = 1'b0;
        r0 = res_cnt;
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        step(); step();
        check("t6b_in_sweep1", u22_sel, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6b_sel", u22_sel, 0);
        check("t6b_busy", busy, 0);
        check("t6b_shadow", shadow(), 0);
        check("t6b_result", result, 0);
        check("t6b_pulses", {cfg_done, cfg_err, res_valid}, 0);
        step();
        rst_n = 1'b1;
        step(); step(); step(); step();
        check("t6b_no_res", res_cnt - r0, 0);
        send_frame(W3, 0, 26, 1'b1, 0);
        step();
        check("t6_post_done", cfg_done, 1);
        check("t6_post_shadow", shadow(), W3);

        check("pulse_overlap", overlap_cnt, 0);
        check("sel_outside_sweep", sel_idle_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
